// File: rtl/elevator_ctrl_n_pkg.sv
// Shared types and helpers for the N-floor elevator controller.
package elev_pkg;

  // Controller states; encoding is also what the debug state output shows.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    ARRIVE = 2'd2,
    DOOR   = 2'd3
  } state_e;

  // Travel direction encoding on the direct output.
  localparam logic UP = 1'b0;
  localparam logic DN = 1'b1;

  // Active-low gfedcba pattern for a decimal digit; blank for anything else.
  function automatic logic [6:0] seg7_digit(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/elevator_ctrl_n_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic power_on,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;

  // Count 0..DIV-1 and wrap; never stops once out of reset.
  always_ff @(posedge clk or negedge power_on) begin
    if (!power_on)           cnt_q <= '0;
    else if (cnt_q == LAST)  cnt_q <= '0;
    else                     cnt_q <= cnt_q + ONE;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/elevator_ctrl_n.sv
// SCAN elevator controller: latches car/hall calls, moves floor by floor,
// stops on calls in the travel direction and manages the door timer.
//
// Handshake note: there is no valid/ready traffic here; buttons are level
// inputs sampled every clock and lamps are the sticky record of a request
// until the car opens its door at that floor in a matching direction.
module elevator_ctrl_n
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS   = 8,
  parameter int TICK_DIV     = 8388608,
  parameter int TRAVEL_TICKS = 11,
  parameter int DOOR_TICKS   = 24
) (
  input  logic                          clk,
  input  logic                          power_on,
  input  logic [NUM_FLOORS-1:0]         car_call,
  input  logic [NUM_FLOORS-1:0]         hall_up,
  input  logic [NUM_FLOORS-1:0]         hall_dn,
  input  logic                          door_open_btn,
  input  logic                          door_close_btn,
  input  logic                          door_obstruct,
  output logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
  output logic                          direct,
  output logic                          moving,
  output logic                          door_open,
  output logic [NUM_FLOORS-1:0]         car_lamp,
  output logic [NUM_FLOORS-1:0]         up_lamp,
  output logic [NUM_FLOORS-1:0]         dn_lamp,
  output logic [6:0]                    seg7,
  output logic [1:0]                    dbg_state_o
);

  localparam int FW   = $clog2(NUM_FLOORS);
  localparam int MAXT = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int N    = NUM_FLOORS;

  localparam logic [FW-1:0] TOP_F     = FW'(N - 1);
  localparam logic [FW-1:0] ONE_F     = FW'(1);
  localparam logic [TW-1:0] ONE_T     = TW'(1);
  localparam logic [TW-1:0] TRAV_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_TICKS - 1);
  localparam logic [N-1:0]  ONE_N     = N'(1);
  // No up call from the top floor, no down call from the ground floor.
  localparam logic [N-1:0]  UP_VALID  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  DN_VALID  = {{(N-1){1'b1}}, 1'b0};

  state_e        state_q;
  logic [FW-1:0] floor_q;
  logic          dir_q;
  logic          moving_q;
  logic          door_q;
  logic [TW-1:0] tmr_q;
  logic [N-1:0]  car_q, up_q, dn_q;
  logic [N-1:0]  car_d, up_d, dn_d;
  logic          tick;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk      (clk),
    .power_on (power_on),
    .tick_o   (tick)
  );

  // Floor masks derived from the one-hot of the current floor.
  logic [N-1:0] here_oh, above_m, below_m, all_req;
  logic         req_above, req_below;
  logic         here_car, here_up, here_dn;

  assign here_oh   = ONE_N << floor_q;
  assign below_m   = here_oh - ONE_N;
  assign above_m   = ~((here_oh << 1) - ONE_N);
  assign all_req   = car_q | up_q | dn_q;
  assign req_above = |(all_req & above_m);
  assign req_below = |(all_req & below_m);
  assign here_car  = |(car_q & here_oh);
  assign here_up   = |(up_q & here_oh);
  assign here_dn   = |(dn_q & here_oh);

  logic eff_dir, base_dir, ahead_base, behind_base;
  logic hall_with, hall_against, serve_here, stop_arrive;
  logic enter_door, door_dir;

  // Scheduling decisions for IDLE and ARRIVE, including the direction the
  // car takes when its door opens.
  always_comb begin
    eff_dir = dir_q;
    if (floor_q == '0)        eff_dir = UP;
    else if (floor_q == TOP_F) eff_dir = DN;
    base_dir     = (state_q == IDLE) ? eff_dir : dir_q;
    ahead_base   = base_dir ? req_below : req_above;
    behind_base  = base_dir ? req_above : req_below;
    hall_with    = base_dir ? here_dn : here_up;
    hall_against = base_dir ? here_up : here_dn;
    // An opposite-direction hall call here waits until nothing lies ahead,
    // otherwise the car would reopen at this floor forever.
    serve_here   = here_car | hall_with | (hall_against & ~ahead_base);
    stop_arrive  = here_car | hall_with | ~ahead_base;
    enter_door   = ((state_q == IDLE) && serve_here) ||
                   ((state_q == ARRIVE) && stop_arrive);
    if (floor_q == '0)         door_dir = UP;
    else if (floor_q == TOP_F) door_dir = DN;
    else                       door_dir = ahead_base ? base_dir : ~base_dir;
  end

  logic         in_door, press_here;
  logic [N-1:0] sup_car, sup_up, sup_dn, clr_car, clr_up, clr_dn;

  // Lamp next-state: set by buttons, cleared on door entry at this floor;
  // presses at this floor while the door is open only refresh the timer.
  always_comb begin
    in_door = (state_q == DOOR);
    sup_car = in_door ? here_oh : '0;
    sup_up  = (in_door && dir_q == UP) ? here_oh : '0;
    sup_dn  = (in_door && dir_q == DN) ? here_oh : '0;
    clr_car = enter_door ? here_oh : '0;
    clr_up  = (enter_door && (base_dir == UP || !ahead_base)) ? here_oh : '0;
    clr_dn  = (enter_door && (base_dir == DN || !ahead_base)) ? here_oh : '0;
    car_d   = (car_q | (car_call & ~sup_car)) & ~clr_car;
    up_d    = (up_q | (hall_up & ~sup_up)) & ~clr_up & UP_VALID;
    dn_d    = (dn_q | (hall_dn & ~sup_dn)) & ~clr_dn & DN_VALID;
    press_here = in_door &&
                 (|((car_call | ((dir_q == UP) ? hall_up : hall_dn)) & here_oh));
  end

  // Request lamp registers.
  always_ff @(posedge clk or negedge power_on) begin
    if (!power_on) begin
      car_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      car_q <= car_d;
      up_q  <= up_d;
      dn_q  <= dn_d;
    end
  end

  // Main controller FSM with registered floor, direction and drive outputs.
  always_ff @(posedge clk or negedge power_on) begin
    if (!power_on) begin
      state_q  <= IDLE;
      floor_q  <= '0;
      dir_q    <= UP;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
      tmr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmr_q <= '0;
          if (enter_door) begin
            state_q <= DOOR;
            door_q  <= 1'b1;
            dir_q   <= door_dir;
          end else if (ahead_base) begin
            state_q  <= MOVE;
            moving_q <= 1'b1;
            dir_q    <= eff_dir;
          end else if (behind_base) begin
            state_q  <= MOVE;
            moving_q <= 1'b1;
            dir_q    <= ~eff_dir;
          end else begin
            dir_q <= eff_dir;
          end
        end
        MOVE: begin
          if (tick) begin
            if (tmr_q == TRAV_LAST) begin
              tmr_q   <= '0;
              state_q <= ARRIVE;
              if (dir_q == UP && floor_q != TOP_F)   floor_q <= floor_q + ONE_F;
              else if (dir_q == DN && floor_q != '0) floor_q <= floor_q - ONE_F;
            end else begin
              tmr_q <= tmr_q + ONE_T;
            end
          end
        end
        ARRIVE: begin
          tmr_q <= '0;
          if (enter_door) begin
            state_q  <= DOOR;
            moving_q <= 1'b0;
            door_q   <= 1'b1;
            dir_q    <= door_dir;
          end else begin
            state_q <= MOVE;
          end
        end
        DOOR: begin
          if (door_open_btn || door_obstruct || press_here) begin
            tmr_q <= '0;
          end else if (door_close_btn) begin
            tmr_q   <= '0;
            state_q <= IDLE;
            door_q  <= 1'b0;
          end else if (tick) begin
            if (tmr_q == DOOR_LAST) begin
              tmr_q   <= '0;
              state_q <= IDLE;
              door_q  <= 1'b0;
            end else begin
              tmr_q <= tmr_q + ONE_T;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cur_floor   = floor_q;
  assign direct      = dir_q;
  assign moving      = moving_q;
  assign door_open   = door_q;
  assign car_lamp    = car_q;
  assign up_lamp     = up_q;
  assign dn_lamp     = dn_q;
  assign seg7        = seg7_digit(4'(floor_q) + 4'd1);
  assign dbg_state_o = state_q;

endmodule
